// File: rtl/mips_pkg.sv
// Shared definitions for the parametrised MIPS register bank:
// default sizes, fixed register indices and the flush FSM encoding.
package mips_pkg;

  localparam int LARGURA_PADRAO  = 16;
  localparam int NUM_REGS_PADRAO = 8;
  localparam int REG_ZERO        = 0;
  localparam int REG_LINK_PADRAO = NUM_REGS_PADRAO - 1;

  typedef enum logic {
    OCIOSO   = 1'b0,
    LIMPANDO = 1'b1
  } estado_t;

endpackage

// File: rtl/banco_registradores_param_if.sv
// Register bank access bundle: write, link, read, scoreboard and flush signals.
// The hazard/pipeline side is the master, the bank is the slave.
interface banco_registradores_param_if #(
  parameter int LARGURA  = 16,
  parameter int NUM_REGS = 8
);
  localparam int LARG_END = $clog2(NUM_REGS);

  logic                permisao_escrita;
  logic [LARG_END-1:0] endereco_regd;
  logic [LARGURA-1:0]  dado_escrita;
  logic                escreve_link;
  logic [LARGURA-1:0]  dado_link;
  logic [LARG_END-1:0] endereco_reg1;
  logic [LARG_END-1:0] endereco_reg2;
  logic [LARGURA-1:0]  valor_reg1;
  logic [LARGURA-1:0]  valor_reg2;
  logic                marca_pendente;
  logic [LARG_END-1:0] endereco_pendente;
  logic                pendente_reg1;
  logic                pendente_reg2;
  logic                limpar;
  logic                ocupado;

  modport master (
    output permisao_escrita, endereco_regd, dado_escrita,
    output escreve_link, dado_link,
    output endereco_reg1, endereco_reg2,
    output marca_pendente, endereco_pendente,
    output limpar,
    input  valor_reg1, valor_reg2, pendente_reg1, pendente_reg2, ocupado
  );

  modport slave (
    input  permisao_escrita, endereco_regd, dado_escrita,
    input  escreve_link, dado_link,
    input  endereco_reg1, endereco_reg2,
    input  marca_pendente, endereco_pendente,
    input  limpar,
    output valor_reg1, valor_reg2, pendente_reg1, pendente_reg2, ocupado
  );

endinterface

// File: rtl/placar_pendencias.sv
// Pending-load scoreboard: one bit per register, set by an issued load,
// cleared by either write port, bulk-cleared by a flush.
module placar_pendencias #(
  parameter int NUM_REGS = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        limpa_tudo,
  input  logic                        limpa_a_en,
  input  logic [$clog2(NUM_REGS)-1:0] limpa_a_end,
  input  logic                        limpa_b_en,
  input  logic [$clog2(NUM_REGS)-1:0] limpa_b_end,
  input  logic                        marca_en,
  input  logic [$clog2(NUM_REGS)-1:0] marca_end,
  input  logic [$clog2(NUM_REGS)-1:0] consulta1,
  input  logic [$clog2(NUM_REGS)-1:0] consulta2,
  output logic                        pendente1,
  output logic                        pendente2
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] prox_pend;
  logic                libera1;
  logic                libera2;

  always_comb begin
    prox_pend = pend;
    if (limpa_a_en) prox_pend[limpa_a_end] = 1'b0;
    if (limpa_b_en) prox_pend[limpa_b_end] = 1'b0;
    if (marca_en)   prox_pend[marca_end]   = 1'b1;
    if (limpa_tudo) prox_pend              = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= prox_pend;
  end

  // A writeback releases the consumer in the same cycle unless a new load re-marks it.
  always_comb begin
    libera1 = ((limpa_a_en && (limpa_a_end == consulta1)) ||
               (limpa_b_en && (limpa_b_end == consulta1))) &&
              !(marca_en && (marca_end == consulta1));
    libera2 = ((limpa_a_en && (limpa_a_end == consulta2)) ||
               (limpa_b_en && (limpa_b_end == consulta2))) &&
              !(marca_en && (marca_end == consulta2));
    pendente1 = pend[consulta1] && !libera1;
    pendente2 = pend[consulta2] && !libera2;
  end

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register bank: two bypassed read ports, general and link write
// ports, pending-load scoreboard and a one-register-per-cycle flush engine.
//   state    | meaning
//   OCIOSO   | normal operation, writes/bypass/scoreboard active
//   LIMPANDO | zeroing register[contador] each cycle, all requests ignored
module banco_registradores_param
  import mips_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int NUM_REGS = NUM_REGS_PADRAO,
  parameter int REG_LINK = NUM_REGS - 1
) (
  input logic                      clock,
  input logic                      reset,
  banco_registradores_param_if.slave bus
);

  localparam int LARG_END = $clog2(NUM_REGS);
  localparam logic [LARG_END-1:0] END_ZERO   = LARG_END'(REG_ZERO);
  localparam logic [LARG_END-1:0] END_LINK   = LARG_END'(REG_LINK);
  localparam logic [LARG_END-1:0] END_ULTIMO = LARG_END'(NUM_REGS - 1);

  logic [LARGURA-1:0]  regs [NUM_REGS];
  estado_t             estado, prox_estado;
  logic [LARG_END-1:0] contador, prox_contador;

  logic ocioso;
  logic esc_geral;
  logic esc_link;
  logic marca_ok;
  logic limpa_tudo;
  logic pend1, pend2;

  logic [LARG_END-1:0] end_leitura   [2];
  logic [LARGURA-1:0]  valor_leitura [2];

  // The limpar cycle itself drops all requests; the bulk clear takes precedence.
  always_comb begin
    ocioso     = (estado == OCIOSO);
    limpa_tudo = ocioso && bus.limpar;
    esc_geral  = ocioso && !bus.limpar && bus.permisao_escrita &&
                 (bus.endereco_regd != END_ZERO);
    esc_link   = ocioso && !bus.limpar && bus.escreve_link && (END_LINK != END_ZERO);
    marca_ok   = ocioso && !bus.limpar && bus.marca_pendente &&
                 (bus.endereco_pendente != END_ZERO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      contador <= '0;
    end else begin
      estado   <= prox_estado;
      contador <= prox_contador;
    end
  end

  always_comb begin
    prox_estado   = estado;
    prox_contador = contador;
    case (estado)
      OCIOSO: begin
        if (bus.limpar) begin
          prox_estado   = LIMPANDO;
          prox_contador = LARG_END'(1);
        end
      end
      LIMPANDO: begin
        if (contador == END_ULTIMO) begin
          prox_estado   = OCIOSO;
          prox_contador = '0;
        end else begin
          prox_contador = contador + LARG_END'(1);
        end
      end
      default: begin
        prox_estado   = OCIOSO;
        prox_contador = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (estado == LIMPANDO) begin
      regs[contador] <= '0;
    end else begin
      if (esc_geral) regs[bus.endereco_regd] <= bus.dado_escrita;
      if (esc_link)  regs[END_LINK]          <= bus.dado_link;
    end
  end

  assign end_leitura[0] = bus.endereco_reg1;
  assign end_leitura[1] = bus.endereco_reg2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      valor_leitura[p] = regs[end_leitura[p]];
      if (ocioso) begin
        if (esc_link && (end_leitura[p] == END_LINK))
          valor_leitura[p] = bus.dado_link;
        else if (esc_geral && (end_leitura[p] == bus.endereco_regd))
          valor_leitura[p] = bus.dado_escrita;
      end
      if (end_leitura[p] == END_ZERO) valor_leitura[p] = '0;
    end
  end

  assign bus.valor_reg1 = valor_leitura[0];
  assign bus.valor_reg2 = valor_leitura[1];

  placar_pendencias #(.NUM_REGS(NUM_REGS)) u_placar (
    .clock       (clock),
    .reset       (reset),
    .limpa_tudo  (limpa_tudo),
    .limpa_a_en  (esc_geral),
    .limpa_a_end (bus.endereco_regd),
    .limpa_b_en  (esc_link),
    .limpa_b_end (END_LINK),
    .marca_en    (marca_ok),
    .marca_end   (bus.endereco_pendente),
    .consulta1   (bus.endereco_reg1),
    .consulta2   (bus.endereco_reg2),
    .pendente1   (pend1),
    .pendente2   (pend2)
  );

  assign bus.pendente_reg1 = ocioso && pend1 && (bus.endereco_reg1 != END_ZERO);
  assign bus.pendente_reg2 = ocioso && pend2 && (bus.endereco_reg2 != END_ZERO);
  assign bus.ocupado       = (estado == LIMPANDO);

endmodule

// File: doc/banco_registradores_param.md
Name: banco_registradores_param

Overview:
Parametrised successor to the 8x16 MIPS register bank, with two combinational read ports and a general write port.
- Adds a dedicated link-register write port for jal, so a writeback and a link write can retire in the same cycle.
- Adds same-cycle write-to-read bypass.
- Adds a per-register pending-load scoreboard for the hazard unit.
- Adds a sequential flush engine that zeroes the bank one register per cycle.

Parameters:
LARGURA, 16, data width of each register
NUM_REGS, 8, number of registers (power of two, >=4); register 0 is hard-wired zero
REG_LINK, NUM_REGS-1, index written by the link port
(localparam) LARG_END = $clog2(NUM_REGS), address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
permisao_escrita  in  1  general write enable
endereco_regd  in  LARG_END  general write address
dado_escrita  in  LARGURA  general write data
escreve_link  in  1  link write enable (jal)
dado_link  in  LARGURA  link write data (PC+1)
endereco_reg1, endereco_reg2  in  LARG_END  read addresses
valor_reg1, valor_reg2  out  LARGURA  read data (combinational)
marca_pendente  in  1  set pending bit for endereco_pendente
endereco_pendente  in  LARG_END  destination of an issued load
pendente_reg1, pendente_reg2  out  1  pending status of read addresses
limpar  in  1  single-cycle pulse starting a flush
ocupado  out  1  high while the flush is running

Behaviour:
- Reset (reset=0, async):
  - all registers 0, all pending bits 0;
  - FSM in OCIOSO, ocupado=0, flush counter 0;
  - read outputs therefore 0.
- Register 0:
  - reads always return 0 and pendente=0;
  - writes and marca to address 0 are ignored.
- Write commit, on the rising edge when FSM=OCIOSO:
  - general write when permisao_escrita=1;
  - link write to REG_LINK when escreve_link=1;
  - both to the same register: link data wins.
- Bypass: if a read address equals a register being written this cycle (non-zero), valor_regX shows the incoming data, using the same priority. Otherwise it shows the stored value. Zero cycles of read latency.
- Scoreboard:
  - a write to register r clears pend[r] at the edge;
  - marca_pendente sets pend[endereco_pendente];
  - set and clear to the same register in the same cycle: set wins.
- Pending outputs:
  - pendente_regX = pend[addr] AND NOT (a write to addr this cycle without a same-register marca);
  - the consumer is therefore released in the writeback cycle.
- FSM, two states:
  - OCIOSO: on limpar=1, go to LIMPANDO. All pending bits clear at that edge, the counter loads 1, and any write in that cycle is dropped.
  - LIMPANDO: each cycle, register[counter] <= 0 and counter increments. When counter = NUM_REGS-1, that register is zeroed and the FSM returns to OCIOSO.
  - Duration: NUM_REGS-1 cycles with ocupado=1 (ocupado is a registered output, high exactly during LIMPANDO).
- While LIMPANDO:
  - permisao_escrita, escreve_link, marca_pendente and limpar are ignored;
  - reads return current array contents with no bypass;
  - pendente outputs read 0.
- Reset asserted mid-flush aborts to the reset state immediately.
- Address arithmetic is unsigned LARG_END bits; no wrap is possible because the counter stops at NUM_REGS-1.

Decomposition:
- Shared package/header mips_pkg: LARGURA and NUM_REGS defaults, REG_ZERO=0, REG_LINK default, FSM state encodings OCIOSO/LIMPANDO.
- One natural sub-module: placar_pendencias (scoreboard bit vector with set/clear/bulk-clear and two lookup ports).
- Storage, bypass and FSM stay in the top module.

Test Plan:
1. Reset low, then high. Read r1..r7 -> all 0. Write r3=0xBEEF; next cycle read r3 -> 0xBEEF. Write r0=0x1234 -> read r0 = 0.
2. Bypass: same cycle, write r5=0x00A5 and read r5 -> valor_reg1=0x00A5 before the edge; after the edge, stored 0x00A5.
3. Collision: permisao_escrita to r7=0x1111 and escreve_link with dado_link=0x2222 in one cycle -> r7=0x2222 after the edge, and the bypass shows 0x2222 in-cycle.
4. Scoreboard: marca r4 -> pendente_reg1(r4)=1 on the next cycle. Write r4 -> pendente 0 in that same cycle, stays 0. Marca and write r4 in the same cycle -> pend stays 1.
5. Flush (NUM_REGS=8): preload r1..r7 non-zero, then pulse limpar.
   - ocupado high for exactly 7 cycles, then all regs 0.
   - A write r2=0xFFFF issued during the flush is lost; one issued the cycle after ocupado falls is kept.
6. Reset mid-flush after 3 cycles -> ocupado=0 immediately, all registers 0. Repeat tests 1-5 with LARGURA=32 and NUM_REGS=16 (flush 15 cycles, REG_LINK=15).
